// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: command and FSM state encodings shared by the arbiter files
package mem_arb_pkg;
  typedef enum logic [1:0] {
    CMD_RD  = 2'b00,
    CMD_WR  = 2'b01,
    CMD_ALU = 2'b10,
    CMD_BAD = 2'b11
  } cmd_e;
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10,
    RESP  = 2'b11
  } state_e;
endpackage

// File: rtl/mem_ctrl_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin pick; on a tie the port not served last wins
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       valid,
  output logic       win
);
  assign valid = |req;
  assign win   = &req ? ~last : req[1];
endmodule

// File: rtl/mem_ctrl_arbiter.sv
// mem_ctrl_arbiter: serialises two requesters onto one memory-controller command port
module mem_ctrl_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 20,
  parameter int TIMEOUT    = 255,
  parameter int TO_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  r0_req,
  input  logic [1:0]            r0_cmd,
  input  logic [3:0]            r0_alu_op,
  input  logic                  r0_alu_ext,
  input  logic [ADDR_WIDTH-1:0] r0_addr,
  input  logic [DATA_WIDTH-1:0] r0_wdata,
  output logic                  r0_gnt,
  output logic                  r0_done,
  output logic                  r0_err,
  output logic [DATA_WIDTH-1:0] r0_rdata,
  input  logic                  r1_req,
  input  logic [1:0]            r1_cmd,
  input  logic [3:0]            r1_alu_op,
  input  logic                  r1_alu_ext,
  input  logic [ADDR_WIDTH-1:0] r1_addr,
  input  logic [DATA_WIDTH-1:0] r1_wdata,
  output logic                  r1_gnt,
  output logic                  r1_done,
  output logic                  r1_err,
  output logic [DATA_WIDTH-1:0] r1_rdata,
  output logic                  mc_we,
  output logic                  mc_re,
  output logic                  mc_alu_start,
  output logic [3:0]            mc_alu_op,
  output logic                  mc_alu_to_external,
  output logic [ADDR_WIDTH-1:0] mc_addr,
  output logic [DATA_WIDTH-1:0] mc_data_in,
  input  logic [DATA_WIDTH-1:0] mc_data_out,
  input  logic                  mc_busy,
  input  logic                  mc_done
);
  state_e                state_q, state_d;
  cmd_e                  cmd_q, cmd_d;
  logic [3:0]            op_q, op_d;
  logic                  ext_q, ext_d, owner_q, owner_d, last_q, last_d, err_q, err_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic [TO_WIDTH-1:0]   cnt_q, cnt_d;
  logic                  win_valid, win, ok, issue, resp;

  rr_arb2 u_rr (.req({r1_req, r0_req}), .last(last_q), .valid(win_valid), .win(win));

  // mc_done while a command is outstanding always beats the timeout
  assign ok = (state_q == ISSUE || state_q == WAIT) && mc_done;

  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    op_d     = op_q;
    ext_d    = ext_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    owner_d  = owner_q;
    last_d   = last_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    rdata0_d = ok && !owner_q ? mc_data_out : rdata0_q;
    rdata1_d = ok && owner_q ? mc_data_out : rdata1_q;
    case (state_q)
      IDLE: if (win_valid && !mc_busy) begin
        owner_d = win;
        last_d  = win;
        cmd_d   = cmd_e'(win ? r1_cmd : r0_cmd);
        op_d    = win ? r1_alu_op : r0_alu_op;
        ext_d   = win ? r1_alu_ext : r0_alu_ext;
        addr_d  = win ? r1_addr : r0_addr;
        wdata_d = win ? r1_wdata : r0_wdata;
        err_d   = cmd_d == CMD_BAD;
        state_d = err_d ? RESP : ISSUE;
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = mc_done ? RESP : WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (mc_done) state_d = RESP;
        else if (cnt_q == TO_WIDTH'(TIMEOUT)) begin
          state_d = RESP;
          err_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cmd_q    <= CMD_RD;
      op_q     <= '0;
      ext_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      op_q     <= op_d;
      ext_q    <= ext_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  assign issue              = state_q == ISSUE;
  assign resp               = state_q == RESP;
  assign mc_re              = issue && cmd_q == CMD_RD;
  assign mc_we              = issue && cmd_q == CMD_WR;
  assign mc_alu_start       = issue && cmd_q == CMD_ALU;
  assign mc_alu_op          = op_q;
  assign mc_alu_to_external = ext_q;
  assign mc_addr            = addr_q;
  assign mc_data_in         = wdata_q;
  assign r0_gnt             = issue && !owner_q;
  assign r1_gnt             = issue && owner_q;
  assign r0_done            = resp && !owner_q;
  assign r1_done            = resp && owner_q;
  assign r0_err             = r0_done && err_q;
  assign r1_err             = r1_done && err_q;
  assign r0_rdata           = rdata0_q;
  assign r1_rdata           = rdata1_q;
endmodule

// File: tb/tb_mem_ctrl_arbiter.sv
// tb_mem_ctrl_arbiter: directed scoreboard bench with a behavioural memory-controller responder
module tb_mem_ctrl_arbiter;
  localparam logic [1:0] RD = 2'b00, WR = 2'b01, ALU = 2'b10, BAD = 2'b11;

  typedef struct {
    bit         port;
    bit         err;
    bit         ck;
    logic [7:0] rd;
  } exp_t;

  logic        clk = 0, reset = 1;
  logic        r0_req = 0, r1_req = 0, r0_alu_ext = 0, r1_alu_ext = 0;
  logic [1:0]  r0_cmd = 0, r1_cmd = 0;
  logic [3:0]  r0_alu_op = 0, r1_alu_op = 0;
  logic [19:0] r0_addr = 0, r1_addr = 0;
  logic [7:0]  r0_wdata = 0, r1_wdata = 0;
  logic        r0_gnt, r1_gnt, r0_done, r1_done, r0_err, r1_err;
  logic [7:0]  r0_rdata, r1_rdata;
  logic        mc_we, mc_re, mc_alu_start, mc_alu_to_external;
  logic [3:0]  mc_alu_op;
  logic [19:0] mc_addr;
  logic [7:0]  mc_data_in, rsp_data = 0;
  logic        mc_busy = 0, rsp_done = 0, inj_done = 0, mc_done;
  logic [7:0]  mem [256];

  int   errors = 0, checks = 0, cyc_n = 0, n_strobe = 0, n_done = 0;
  int   strobe_cyc = 0, done_cyc = 0, pend = 0, lat = 0;
  bit   resp_en = 1;
  logic [2:0]  strobe_kind = 0;
  logic [1:0]  strobe_gnt = 0;
  logic [4:0]  strobe_aux = 0;
  logic [19:0] strobe_addr = 0;
  logic [1:0]  gq [$];
  exp_t        q [$];

  assign mc_done = rsp_done | inj_done;

  mem_ctrl_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(20), .TIMEOUT(4), .TO_WIDTH(8)) dut (
    .clk(clk), .reset(reset),
    .r0_req(r0_req), .r0_cmd(r0_cmd), .r0_alu_op(r0_alu_op), .r0_alu_ext(r0_alu_ext),
    .r0_addr(r0_addr), .r0_wdata(r0_wdata), .r0_gnt(r0_gnt), .r0_done(r0_done),
    .r0_err(r0_err), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_cmd(r1_cmd), .r1_alu_op(r1_alu_op), .r1_alu_ext(r1_alu_ext),
    .r1_addr(r1_addr), .r1_wdata(r1_wdata), .r1_gnt(r1_gnt), .r1_done(r1_done),
    .r1_err(r1_err), .r1_rdata(r1_rdata),
    .mc_we(mc_we), .mc_re(mc_re), .mc_alu_start(mc_alu_start), .mc_alu_op(mc_alu_op),
    .mc_alu_to_external(mc_alu_to_external), .mc_addr(mc_addr), .mc_data_in(mc_data_in),
    .mc_data_out(rsp_data), .mc_busy(mc_busy), .mc_done(mc_done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: respond as the memory controller, then score any done pulse
  task automatic cyc();
    exp_t e;
    @(posedge clk);
    #1;
    cyc_n++;
    rsp_done = 0;
    if (reset) pend = 0;
    else if (pend > 0) begin
      pend--;
      if (pend == 0) rsp_done = 1;
    end
    if (mc_we | mc_re | mc_alu_start) begin
      n_strobe++;
      strobe_cyc  = cyc_n;
      strobe_kind = {mc_we, mc_re, mc_alu_start};
      strobe_gnt  = {r1_gnt, r0_gnt};
      strobe_aux  = {mc_alu_to_external, mc_alu_op};
      strobe_addr = mc_addr;
      gq.push_back(strobe_gnt);
      if (mc_we) begin
        mem[mc_addr[7:0]] = mc_data_in;
        rsp_data = 8'h00;
      end else if (mc_re) rsp_data = mem[mc_addr[7:0]];
      else rsp_data = mc_data_in + {4'b0, mc_alu_op};
      if (resp_en) begin
        if (lat == 0) rsp_done = 1;
        else pend = lat;
      end
    end
    if (r0_done | r1_done) begin
      n_done++;
      done_cyc = cyc_n;
      chk("single_done", 32'(r0_done & r1_done), 32'(0));
      if (q.size() == 0) chk("unexpected_done", 32'(n_done), 32'(0));
      else begin
        e = q.pop_front();
        chk("done_port", 32'(r1_done), 32'(e.port));
        chk("done_err", 32'(r1_done ? r1_err : r0_err), 32'(e.err));
        if (e.ck) chk("rdata", 32'(r1_done ? r1_rdata : r0_rdata), 32'(e.rd));
      end
      if (r0_done) r0_req = 0;
      if (r1_done) r1_req = 0;
    end
  endtask

  task automatic issue(input bit p, input logic [1:0] cmd, input logic [3:0] op, input bit ext,
                       input logic [19:0] addr, input logic [7:0] wd,
                       input bit err, input bit ck, input logic [7:0] rd);
    exp_t e;
    if (p) begin
      r1_req = 1; r1_cmd = cmd; r1_alu_op = op; r1_alu_ext = ext; r1_addr = addr; r1_wdata = wd;
    end else begin
      r0_req = 1; r0_cmd = cmd; r0_alu_op = op; r0_alu_ext = ext; r0_addr = addr; r0_wdata = wd;
    end
    e.port = p; e.err = err; e.ck = ck; e.rd = rd;
    q.push_back(e);
  endtask

  // Run until the scoreboard is empty, then one more cycle so the FSM is back in IDLE
  task automatic drain(input int lim);
    int k = 0;
    while (q.size() != 0 && k < lim) begin
      cyc();
      k++;
    end
    chk("drain", 32'(q.size()), 32'(0));
    cyc();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_pulses"}, 32'({r0_gnt, r1_gnt, r0_done, r1_done, r0_err, r1_err,
                                mc_we, mc_re, mc_alu_start}), 32'(0));
    chk({tag, "_rdata"}, 32'({r0_rdata, r1_rdata}), 32'(0));
    chk({tag, "_cmdregs"}, 32'({mc_addr, mc_alu_op, mc_alu_to_external}), 32'(0));
    chk({tag, "_wdata"}, 32'(mc_data_in), 32'(0));
  endtask

  initial begin
    int s0, c, nd, k;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h3C;
    repeat (3) cyc();
    chk_zero("reset");
    reset = 0;
    cyc();

    // Tie after reset: r0, then r1; r0 re-requests straight away and now loses the tie
    gq.delete();
    issue(0, RD, 0, 0, 20'h00010, 0, 0, 1, 8'h2C);
    issue(1, RD, 0, 0, 20'h00020, 0, 0, 1, 8'h1C);
    k = 0;
    while (n_done < 1 && k < 20) begin
      cyc();
      k++;
    end
    chk("tie_first_done", 32'(n_done), 32'(1));
    issue(0, RD, 0, 0, 20'h00030, 0, 0, 1, 8'h0C);
    drain(40);
    chk("tie_count", 32'(gq.size()), 32'(3));
    chk("tie_order", 32'({gq[0], gq[1], gq[2]}), 32'(6'b01_10_01));

    // r0 write then read back, with zero and two-cycle controller latency
    lat = 0;
    issue(0, WR, 0, 0, 20'h00010, 8'hA5, 0, 0, 8'h00);
    drain(20);
    chk("wr_kind", 32'(strobe_kind), 32'(3'b100));
    chk("wr_gnt", 32'(strobe_gnt), 32'(2'b01));
    chk("wr_addr", 32'(strobe_addr), 32'h10);
    chk("wr_lat", 32'(done_cyc - strobe_cyc), 32'(1));
    lat = 2;
    c = cyc_n;
    issue(0, RD, 0, 0, 20'h00010, 0, 0, 1, 8'hA5);
    drain(20);
    chk("rd_kind", 32'(strobe_kind), 32'(3'b010));
    chk("rd_issue_lat", 32'(strobe_cyc - c), 32'(1));
    chk("rd_lat", 32'(done_cyc - strobe_cyc), 32'(3));

    // ALU on r1 to external memory
    lat = 1;
    issue(1, ALU, 4'h3, 1, 20'h00055, 8'h10, 0, 1, 8'h13);
    drain(20);
    chk("alu_kind", 32'(strobe_kind), 32'(3'b001));
    chk("alu_opext", 32'(strobe_aux), 32'(5'h13));
    chk("alu_gnt", 32'(strobe_gnt), 32'(2'b10));

    // Busy hold-off
    lat = 0;
    mc_busy = 1;
    s0 = n_strobe;
    issue(1, RD, 0, 0, 20'h00020, 0, 0, 1, 8'h1C);
    repeat (5) cyc();
    chk("busy_hold", 32'(n_strobe), 32'(s0));
    mc_busy = 0;
    c = cyc_n;
    cyc();
    chk("busy_release", 32'(n_strobe), 32'(s0 + 1));
    chk("busy_strobe_cyc", 32'(strobe_cyc), 32'(c + 1));
    drain(20);

    // Illegal command on r1: done+err next cycle, no strobe, rdata kept
    s0 = n_strobe;
    c = cyc_n;
    issue(1, BAD, 0, 0, 20'h00077, 8'h99, 1, 1, 8'h1C);
    cyc();
    chk("bad_done_cyc", 32'(done_cyc), 32'(c + 1));
    drain(20);
    chk("bad_no_strobe", 32'(n_strobe), 32'(s0));

    // Timeout on r0, then a stray mc_done in IDLE
    resp_en = 0;
    issue(0, RD, 0, 0, 20'h00040, 0, 1, 1, 8'hA5);
    drain(30);
    chk("to_lat", 32'(done_cyc - strobe_cyc), 32'(6));
    nd = n_done;
    s0 = n_strobe;
    inj_done = 1;
    cyc();
    inj_done = 0;
    repeat (3) cyc();
    chk("ghost_done", 32'(n_done), 32'(nd));
    chk("ghost_strobe", 32'(n_strobe), 32'(s0));

    // Reset while waiting on the controller
    s0 = n_strobe;
    issue(1, RD, 0, 0, 20'h00020, 0, 0, 1, 8'h1C);
    k = 0;
    while (n_strobe == s0 && k < 10) begin
      cyc();
      k++;
    end
    chk("rst_strobe", 32'(n_strobe), 32'(s0 + 1));
    cyc();
    cyc();
    void'(q.pop_back());
    reset = 1;
    r1_req = 0;
    cyc();
    chk_zero("midreset");
    reset = 0;
    nd = n_done;
    repeat (3) cyc();
    chk("rst_no_done", 32'(n_done), 32'(nd));
    resp_en = 1;
    lat = 1;
    issue(1, RD, 0, 0, 20'h00020, 0, 0, 1, 8'h1C);
    drain(20);
    chk("post_rst_gnt", 32'(strobe_gnt), 32'(2'b10));
    chk("post_rst_r0", 32'(r0_rdata), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_ctrl_arbiter.md
# mem_ctrl_arbiter

Two-requester round-robin arbiter in front of `memory_controller`. It serialises read, write and ALU commands from a host port (r0) and a secondary port (r1, e.g. DMA or stack sequencer) onto the controller's single command interface. It tracks each transaction to completion, returns read/ALU data to the winner, and aborts hung transactions with an error after a timeout.

## Interface
Parameters:
- `DATA_WIDTH`, 8, data width
- `ADDR_WIDTH`, 20, address width (matches external address space)
- `TIMEOUT`, 255, max cycles waited for `mc_done` (1..2^TO_WIDTH-1)
- `TO_WIDTH`, 8, timeout counter width

Ports (N = 0, 1):
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  synchronous, active-high
- `rN_req`  in  1  request; held with command fields until `rN_done`
- `rN_cmd`  in  2  00 read, 01 write, 10 ALU, 11 illegal
- `rN_alu_op`  in  4  ALU opcode
- `rN_alu_ext`  in  1  ALU result to external (stack) memory
- `rN_addr`  in  ADDR_WIDTH  address
- `rN_wdata`  in  DATA_WIDTH  write data / ALU operand
- `rN_gnt`  out  1  one-cycle pulse: command issued for this port
- `rN_done`  out  1  one-cycle pulse: transaction finished
- `rN_err`  out  1  valid with `rN_done`: illegal cmd or timeout
- `rN_rdata`  out  DATA_WIDTH  result; updated only on a successful completion for port N
- `mc_we`, `mc_re`, `mc_alu_start`  out  1  one-cycle command strobes
- `mc_alu_op`  out  4; `mc_alu_to_external`  out  1
- `mc_addr`  out  ADDR_WIDTH; `mc_data_in`  out  DATA_WIDTH
- `mc_data_out`  in  DATA_WIDTH; `mc_busy`  in  1; `mc_done`  in  1

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE:**
  - Stays in IDLE while `mc_busy`=1 or no request.
  - Otherwise picks a winner and latches its cmd/op/ext/addr/wdata into command registers.
  - If cmd=11: goes to RESP with err=1 and issues no downstream strobe.
  - Else goes to ISSUE.
- **Arbitration:**
  - Single requester wins.
  - If both request, the port not served last wins.
  - `last` pointer resets to 1, so r0 wins the first tie.
  - `last` updates on every transition out of IDLE, including illegal-command responses.
- **ISSUE (1 cycle):**
  - Exactly one of `mc_we`/`mc_re`/`mc_alu_start` =1, plus `rN_gnt`=1.
  - The timeout counter clears.
  - If `mc_done`=1 this cycle, go to RESP; else go to WAIT.
- **WAIT:**
  - The counter increments each cycle.
  - `mc_done`=1: capture `mc_data_out`, go to RESP (err=0).
  - Counter reaches TIMEOUT without `mc_done`: go to RESP with err=1; `rdata` is unchanged.
  - If `mc_done` and the timeout coincide, `mc_done` wins.
- **RESP (1 cycle):**
  - `rN_done`=1, `rN_err` as latched.
  - `rN_rdata` is updated on read/ALU success (write success also loads `mc_data_out`, value don't-care).
  - Next state is IDLE.
- Requests sampled during ISSUE/WAIT/RESP are ignored. Dropping `rN_req` mid-transaction does not cancel it; completion is still signalled.
- A requester must drop `req` in the cycle after seeing `done`, or it is treated as a new request.
- `mc_alu_op`/`mc_alu_to_external`/`mc_addr`/`mc_data_in` are driven from the command registers, stable from ISSUE through RESP.
- **Reset** (at any point, including mid-transaction):
  - State returns to IDLE and `last` returns to 1.
  - All strobes, `gnt`, `done` and `err` go to 0; `rdata` and the command registers go to 0; the counter goes to 0.
  - An in-flight transaction is dropped without a done pulse.

## Timing
- All outputs are registered from the state and command registers; there are no combinational in→out paths.
- Request seen in IDLE at edge N → ISSUE in cycle N+1 (strobe + gnt) → earliest `mc_done` sampled in ISSUE → `done` in cycle N+2.
- `mc_done` sampled in WAIT at cycle M → `done`/`rdata` at M+1 → IDLE at M+2.
- Minimum spacing between strobes is 3 cycles.
- Illegal command: request at N → `done`+`err` at N+1.
- Timeout: `err` asserts TIMEOUT+2 cycles after the strobe cycle.

## Structure
- Shared package `mem_arb_pkg`:
  - cmd encodings CMD_RD=2'b00, CMD_WR=2'b01, CMD_ALU=2'b10, CMD_BAD=2'b11
  - FSM state encodings
- One sub-module is natural: `rr_arb2` (combinational 2-way round-robin pick from req[1:0] and `last`). The FSM, command registers, `last` and the timeout counter stay in the top.

## Test plan
- **r0 write then read:** r0 write addr 0x00010 data 0xA5 → `mc_we` pulse, `r0_done` with err=0. Then r0 read 0x00010 → `mc_re`, `r0_rdata`=0xA5.
- **Tie after reset:** both request reads in the same cycle → r0 granted first, r1 granted second. A repeated tie grants r1 first.
- **Busy hold-off:** `mc_busy`=1 for 5 cycles with r1 requesting → no strobe until the cycle after `busy` falls.
- **Illegal command:** r1 cmd=11 → `r1_done`=1 and `r1_err`=1 one cycle later, no `mc_*` strobe, `rdata` unchanged.
- **Timeout:** TIMEOUT=4, `mc_done` held 0 → `r0_err`/`r0_done` 6 cycles after `mc_re`. A later `mc_done` pulse in IDLE is ignored.
- **Reset mid-op:** assert `reset` in WAIT → next cycle all outputs 0, no `done`. A new r1 request then completes normally.
